// File: rtl/wb_pipe_skid.sv
// MEM->WB writeback register with a two-entry skid buffer, so WB can stall
// without a combinational ready path into MEM; also flush, freeze and forwarding.
module wb_pipe_skid #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 5,
    parameter int ZERO_SUPPRESS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_wd,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_wreg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_wd,
    output logic [DATA_W-1:0] out_data,
    output logic              out_wreg,
    output logic              wb_we,
    output logic [1:0]        occ,
    input  logic [ADDR_W-1:0] q_addr,
    output logic              q_hit,
    output logic [DATA_W-1:0] q_data
);

    typedef struct packed {
        logic [ADDR_W-1:0] wd;
        logic [DATA_W-1:0] data;
        logic              wreg;
    } ent_t;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    localparam bit ZS = (ZERO_SUPPRESS != 0);

    state_t state, state_nx;
    ent_t   main_q, skid_q, cap;
    logic   acc_in, acc_out;
    logic   main_v, skid_v, main_hit, skid_hit;

    // x0 writes are neutralised at capture so nothing downstream has to care
    always_comb begin
        cap      = '0;
        cap.wd   = in_wd;
        cap.data = in_data;
        cap.wreg = in_wreg & ~(ZS & (in_wd == '0));
    end

    assign main_v  = (state != EMPTY);
    assign skid_v  = (state == TWO);
    assign acc_in  = in_valid & in_ready;
    assign acc_out = out_valid & out_ready & rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= EMPTY;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = EMPTY;
        end else if (rdy) begin
            case (state)
                EMPTY: if (acc_in) state_nx = ONE;
                ONE: begin
                    if (acc_in && !acc_out)      state_nx = TWO;
                    else if (!acc_in && acc_out) state_nx = EMPTY;
                end
                TWO:   if (acc_out) state_nx = ONE;
                default: state_nx = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (rdy) begin
            case (state)
                EMPTY: if (acc_in) main_q <= cap;
                ONE: begin
                    if (acc_in && acc_out) main_q <= cap;
                    else if (acc_in)       skid_q <= cap;
                end
                TWO:   if (acc_out) main_q <= skid_q;
                default: ;
            endcase
        end
    end

    // ready depends only on registered state, never on out_ready
    always_comb begin
        in_ready  = rst & rdy & (state != TWO);
        out_valid = main_v;
        out_wd    = main_v ? main_q.wd   : '0;
        out_data  = main_v ? main_q.data : '0;
        out_wreg  = main_v ? main_q.wreg : 1'b0;
        wb_we     = out_valid & out_wreg & out_ready & rdy;
        occ       = state;
        main_hit  = main_v & main_q.wreg & (main_q.wd == q_addr) & (q_addr != '0);
        skid_hit  = skid_v & skid_q.wreg & (skid_q.wd == q_addr) & (q_addr != '0);
        q_hit     = main_hit | skid_hit;
        q_data    = '0;
        if (skid_hit)      q_data = skid_q.data;
        else if (main_hit) q_data = main_q.data;
    end

endmodule
